// File: rtl/mem_stream_pkg.sv
// Shared constants, FSM state type and length clamp for the RAM stream reader.
package mem_stream_pkg;

  localparam int MEM_ADDR_W  = 10;
  localparam int MEM_DATA_W  = 32;
  localparam int MEM_MAX_LEN = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ZERO  = 3'd4
  } reader_state_t;

  // Requests longer than the RAM are truncated to one full sweep of it.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Small synchronous FIFO holding returned RAM words until the stream takes them.
module stream_sync_fifo #(
  parameter  int W     = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    w_do_push, w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is cleared on reset so the head word reads as zero when idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/mem_1_stream_reader.sv
// Reads a run of RAM words through port s2 and emits them as one sop/eop frame.
module mem_1_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_start_addr,
  input  logic [ADDR_W:0]     i_length,
  output logic                o_busy,
  output logic                o_done,
  output logic [ADDR_W-1:0]   o_mem_address,
  output logic                o_mem_chipselect,
  output logic                o_mem_clken,
  output logic                o_mem_write,
  output logic [DATA_W/8-1:0] o_mem_byteenable,
  input  logic [DATA_W-1:0]   i_mem_readdata,
  output logic [DATA_W-1:0]   o_out_data,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic                o_out_sop,
  output logic                o_out_eop
);

  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam int          OW      = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int unsigned MAX_LEN = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LEN_ZERO = '0;
  localparam logic [ADDR_W:0] LEN_ONE  = 1;

  if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least RD_LAT+1");
  end

  reader_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining, r_beats_left;
  logic              r_first;
  logic [RD_LAT-1:0] r_vld_pipe;

  logic [ADDR_W:0]   w_len;
  logic              w_accept, w_first_issue, w_issue, w_credit;
  logic              w_push, w_pop, w_full, w_empty;
  logic [CW-1:0]     w_count;
  logic [OW-1:0]     w_inflight;
  logic [DATA_W-1:0] w_rdata;

  assign w_len    = (ADDR_W + 1)'(clamp_len(32'(i_length), MAX_LEN));
  assign w_accept = !i_reset && (r_state == IDLE) && i_start;
  // The first read goes out in the start cycle itself; that is what keeps
  // start-to-first-beat at RD_LAT+1.
  assign w_first_issue = w_accept && (w_len != LEN_ZERO);
  assign w_credit = !w_full && ((w_inflight + OW'(w_count)) < OW'(FIFO_DEPTH));
  assign w_issue  = w_first_issue ||
                    (!i_reset && (r_state == ISSUE) && (r_remaining != LEN_ZERO) && w_credit);
  assign w_push   = r_vld_pipe[RD_LAT-1];
  assign w_pop    = !w_empty && i_out_ready;

  // Words requested but not yet returned by the RAM.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + OW'(r_vld_pipe[i]);
  end

  // Frame FSM, address/length counters and read-latency tracker.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_beats_left <= '0;
      r_first      <= 1'b0;
      r_vld_pipe   <= '0;
    end else begin
      r_vld_pipe <= (r_vld_pipe << 1) | RD_LAT'(w_issue);
      if (w_issue) r_addr <= o_mem_address + 1'b1;
      if (w_pop) begin
        r_beats_left <= r_beats_left - 1'b1;
        r_first      <= 1'b0;
      end
      case (r_state)
        IDLE: if (i_start) begin
          if (w_len == LEN_ZERO) begin
            r_state <= ZERO;
          end else begin
            r_state      <= (w_len == LEN_ONE) ? DRAIN : ISSUE;
            r_remaining  <= w_len - 1'b1;
            r_beats_left <= w_len;
            r_first      <= 1'b1;
          end
        end
        ISSUE: if (w_issue) begin
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == LEN_ONE) r_state <= DRAIN;
        end
        DRAIN: if (w_pop && (r_beats_left == LEN_ONE)) r_state <= DONE;
        DONE:  r_state <= IDLE;
        ZERO:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  stream_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_wdata (i_mem_readdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_busy           = (r_state != IDLE);
  assign o_done           = (r_state == DONE) || (r_state == ZERO);
  assign o_mem_address    = w_first_issue ? i_start_addr : r_addr;
  assign o_mem_chipselect = w_issue;
  assign o_mem_clken      = 1'b1;
  assign o_mem_write      = 1'b0;
  assign o_mem_byteenable = '1;
  assign o_out_data       = w_rdata;
  assign o_out_valid      = !w_empty;
  assign o_out_sop        = !w_empty && r_first;
  assign o_out_eop        = !w_empty && (r_beats_left == LEN_ONE);

endmodule

// File: tb/tb_mem_1_stream_reader.sv
// Randomised bench for mem_1_stream_reader against a queue-based frame model.
module tb_mem_1_stream_reader;
  localparam int AW = 10, DW = 32, RD_LAT = 2, DEPTH = 4;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, ordy = 1'b1;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic busy, done, cs, clken, wr, ov, sop, eop;
  logic [AW-1:0] addr;
  logic [DW/8-1:0] be;
  logic [DW-1:0] rdata, odata;

  int vectors = 0, miscompares = 0;
  int cyc = 0, ready_pct = 100;

  logic [DW-1:0] ram [0:1023];
  logic [DW-1:0] p1 = '0, p2 = '0;

  typedef struct { logic [DW-1:0] data; bit sop; bit eop; int rdy; } beat_t;
  beat_t pend[$], fq[$];
  bit m_busy = 0, m_done = 0;
  logic [AW-1:0] m_next = '0;
  int cs_total = 0, xfer_total = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  // observation log for hand-computed checks
  int beats_seen, cs_seen, done_seen, start_cyc, first_cyc;
  logic [DW-1:0] first_data, last_data;
  bit first_sop, last_eop, both_seen;
  logic [AW-1:0] addr_log[$];

  mem_1_stream_reader dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_start_addr(start_addr),
    .i_length(length), .o_busy(busy), .o_done(done), .o_mem_address(addr),
    .o_mem_chipselect(cs), .o_mem_clken(clken), .o_mem_write(wr),
    .o_mem_byteenable(be), .i_mem_readdata(rdata), .o_out_data(odata),
    .o_out_valid(ov), .i_out_ready(ordy), .o_out_sop(sop), .o_out_eop(eop)
  );

  always #5 clk = ~clk;

  // RAM port with a two-cycle read latency
  always @(posedge clk) begin
    p1 <= ram[addr];
    p2 <= p1;
  end
  assign rdata = p2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single compare process: model advances one cycle per negedge.
  always @(negedge clk) begin
    bit exp_cs, exp_v, n_busy, n_done, accepted;
    int n;
    beat_t b;
    cyc++;
    if (reset) begin
      pend.delete(); fq.delete();
      m_busy = 0; m_done = 0; prev_stall = 0;
      cs_total = 0; xfer_total = 0;
    end else begin
      accepted = 0; n = 0;
      if (start && !m_busy) begin
        n = (int'(length) > 1024) ? 1024 : int'(length);
        for (int i = 0; i < n; i++) begin
          logic [AW-1:0] ai;
          ai = start_addr + AW'(i);
          b.data = ram[ai]; b.sop = (i == 0); b.eop = (i == n - 1); b.rdy = 0;
          pend.push_back(b);
        end
        m_next = start_addr; start_cyc = cyc; accepted = 1;
      end
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      exp_cs = (pend.size() > 0) && (fq.size() < DEPTH);
      chk("chipselect", cs, exp_cs);
      if (cs) begin cs_seen++; cs_total++; addr_log.push_back(addr); end
      if (exp_cs) begin
        chk("mem_address", addr, m_next);
        b = pend.pop_front(); b.rdy = cyc + RD_LAT + 1; fq.push_back(b);
        m_next = m_next + 1'b1;
      end
      chk("occupancy_le_depth", (cs_total - xfer_total) <= DEPTH, 1);
      exp_v = (fq.size() > 0) && (fq[0].rdy <= cyc);
      chk("out_valid", ov, exp_v);
      if (ov && exp_v) begin
        chk("out_data", odata, fq[0].data);
        chk("out_sop", sop, fq[0].sop);
        chk("out_eop", eop, fq[0].eop);
      end
      if (prev_stall && ov) chk("stall_stable", odata, prev_data);
      prev_stall = ov && !ordy; prev_data = odata;
      n_busy = m_busy; n_done = 0;
      if (accepted) begin n_busy = 1; if (n == 0) n_done = 1; end
      if (exp_v && ordy) begin b = fq.pop_front(); if (b.eop) n_done = 1; end
      if (ov && ordy) begin
        xfer_total++;
        if (beats_seen == 0) begin first_cyc = cyc; first_data = odata; first_sop = sop; end
        beats_seen++; last_data = odata; last_eop = eop;
        if (sop && eop) both_seen = 1;
      end
      if (done) done_seen++;
      if (m_done) n_busy = 0;
      m_busy = n_busy; m_done = n_done;
    end
  end

  // consumer ready, randomised per cycle when ready_pct < 100
  initial forever begin
    @(posedge clk); #1;
    ordy = ($urandom_range(99) < ready_pct);
  end

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] l);
    @(posedge clk); #1;
    beats_seen = 0; cs_seen = 0; done_seen = 0; both_seen = 0; first_cyc = -1;
    addr_log.delete();
    start = 1; start_addr = a; length = l;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (done_seen == 0 && k < lim) begin @(negedge clk); k++; end
    chk("done_within_budget", done_seen != 0, 1);
  endtask

  task automatic run_frame(input logic [AW-1:0] a, input logic [AW:0] l);
    pulse_start(a, l);
    wait_done(5000);
  endtask

  task automatic check_reset_vals();
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);
    chk("rst_cs", cs, 0);       chk("rst_addr", addr, 0);
    chk("rst_valid", ov, 0);    chk("rst_sop", sop, 0);
    chk("rst_eop", eop, 0);     chk("rst_data", odata, 0);
  endtask

  initial begin
    logic [AW-1:0] exp_wrap [4];
    int k;
    exp_wrap = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    for (int i = 0; i < 8; i++) ram[16 + i] = 32'hA0 + i;

    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_reset_vals();
    chk("static_clken", clken, 1); chk("static_write", wr, 0); chk("static_be", be, 4'hF);

    // basic frame with ready high
    run_frame(10'h010, 11'd8);
    chk("t1_beats", beats_seen, 8);
    chk("t1_latency", first_cyc - start_cyc, 3);
    chk("t1_first", first_data, 32'hA0);
    chk("t1_last", last_data, 32'hA7);
    chk("t1_sop", first_sop, 1);
    chk("t1_eop", last_eop, 1);
    @(negedge clk);
    chk("t1_busy_after_done", busy, 0);

    // address wrap
    run_frame(10'h3FE, 11'd4);
    chk("t2_beats", beats_seen, 4);
    for (int i = 0; i < 4; i++) chk("t2_addr", addr_log[i], exp_wrap[i]);

    // backpressure
    ready_pct = 50;
    run_frame(AW'($urandom), 11'd16);
    chk("t3_beats", beats_seen, 16);

    // zero length, length one, oversize
    ready_pct = 100;
    run_frame(10'h123, 11'd0);
    chk("t4_zero_beats", beats_seen, 0);
    chk("t4_zero_cs", cs_seen, 0);
    run_frame(10'h0AA, 11'd1);
    chk("t4_one_beats", beats_seen, 1);
    chk("t4_one_sop_eop", both_seen, 1);
    ready_pct = 70;
    run_frame(10'h200, 11'd2000);
    chk("t4_clamp_beats", beats_seen, 1024);

    // reset mid-frame
    ready_pct = 100;
    pulse_start(10'h100, 11'd10);
    k = 0;
    while (beats_seen < 5 && k < 100) begin @(negedge clk); k++; end
    chk("t5_reached_5", beats_seen >= 5, 1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    done_seen = 0;
    @(negedge clk);
    check_reset_vals();
    repeat (10) @(negedge clk);
    chk("t5_no_done", done_seen, 0);
    run_frame(10'h000, 11'd3);
    chk("t5_after_beats", beats_seen, 3);

    // start while busy is ignored
    pulse_start(10'h300, 11'd12);
    repeat (3) @(posedge clk);
    #1 start = 1; start_addr = 10'h050; length = 11'd5;
    @(posedge clk); #1 start = 0;
    wait_done(500);
    chk("t6_beats", beats_seen, 12);
    chk("t6_first_addr", addr_log[0], 10'h300);
    chk("t6_last_addr", addr_log[addr_log.size() - 1], 10'h30B);

    // random frames under random backpressure
    for (int r = 0; r < 6; r++) begin
      int l;
      l = $urandom_range(40, 1);
      ready_pct = $urandom_range(90, 30);
      run_frame(AW'($urandom), 11'(l));
      chk("rand_beats", beats_seen, l);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_1_stream_reader.md
Name: mem_1_stream_reader

Overview:
- Read-side master for port s2 of the dual-port 1024x32 on-chip RAM.
- On a start command, fetches LENGTH consecutive 32-bit words beginning at START_ADDR and emits them as one framed stream (sop/eop) with valid/ready backpressure. The frame feeds the SFP transmit path.
- Absorbs the RAM's fixed read latency with credit-based issue and a small output FIFO, so no word is ever dropped or duplicated under backpressure.

Parameters:
- ADDR_W, 10, RAM word-address width; RAM depth = 2**ADDR_W.
- DATA_W, 32, RAM and stream data width.
- RD_LAT, 2, cycles from address/chipselect to valid readdata; fixed by RAM configuration.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+1, or elaboration error.

Ports:
- clk  in  1  single clock for all logic and the RAM port.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle command pulse.
- start_addr  in  ADDR_W  first word address, sampled with start.
- length  in  ADDR_W+1  frame length in words, sampled with start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when frame complete.
- mem_address  out  ADDR_W  to RAM address2.
- mem_chipselect  out  1  to RAM chipselect2; high on issue cycles only.
- mem_clken  out  1  to RAM clken2; constant 1.
- mem_write  out  1  to RAM write2; constant 0.
- mem_byteenable  out  DATA_W/8  to RAM byteenable2; all ones.
- mem_readdata  in  DATA_W  from RAM readdata2.
- out_data  out  DATA_W  stream payload.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from the consumer.
- out_sop  out  1  qualifies the first beat.
- out_eop  out  1  qualifies the last beat.

Behaviour:
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_sop=0, out_eop=0, out_data=0. The FIFO empties and the in-flight tracker clears.
- Reset mid-frame: the frame is abandoned and no done pulse is produced. In-flight readdata returning after reset is ignored.
- States:
  - IDLE: start with 1 <= length <= 1024 → ISSUE. Latch addr=start_addr, remaining=length, beats_left=length.
  - IDLE: start with length=0 → ZERO.
  - IDLE: start with length > 1024 → clamp to 1024 and proceed as above.
  - ISSUE: all reads issued → DRAIN.
  - DRAIN: last beat accepted → DONE.
  - ZERO: one cycle, done=1 → IDLE. No beats are emitted.
  - DONE: one cycle, done=1 → IDLE.
- busy=1 in every state except IDLE. start while busy is ignored.
- Issue rule: a read issues in any cycle with remaining>0 and (inflight + fifo_count) < FIFO_DEPTH.
  - On issue: mem_chipselect=1, mem_address=addr, addr increments mod 2**ADDR_W (0x3FF wraps to 0x000), remaining decrements.
- In-flight tracking: an RD_LAT-deep valid shift register. A bit exiting the register pushes mem_readdata into the FIFO. The credit rule guarantees the FIFO is never pushed while full.
- Output: out_valid = FIFO not empty. A beat transfers when out_valid && out_ready.
  - out_data must be held stable while out_valid=1 and out_ready=0.
  - out_sop=1 on the first beat of the frame. out_eop=1 when beats_left==1.
  - length=1 gives sop and eop on the same beat.
- Latency: with out_ready held high, the first beat appears RD_LAT+1 cycles after start. Sustained throughput is 1 word/cycle.
- Simultaneous FIFO push and pop in one cycle are both honoured.
- done is asserted in the cycle after the eop beat transfers.
- A new start is accepted on the cycle after done.

Decomposition:
- Package mem_stream_pkg:
  - constants MEM_ADDR_W=10, MEM_DATA_W=32, MEM_MAX_LEN=1024;
  - enum reader_state_t {IDLE, ISSUE, DRAIN, DONE, ZERO};
  - function clamp_len.
- One sub-module: stream_sync_fifo (parameterised width/depth, same clk and reset, push/pop/full/empty/count).

Test Plan:
- Load RAM[0x010..0x017] = 0xA0..0xA7, start_addr=0x010, length=8, out_ready=1 → beats 0xA0..0xA7 on consecutive cycles; first beat 3 cycles after start; sop on 0xA0, eop on 0xA7; done the cycle after eop; busy falls with done.
- start_addr=0x3FE, length=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001; data in that order.
- length=16, out_ready toggled pseudo-randomly (50%) → exactly 16 beats, in order, no duplicates; out_data stable while stalled; inflight+fifo_count never exceeds 4.
- length=0 → done pulse, no out_valid, no chipselect. length=1 → one beat with sop=eop=1. length=2000 → exactly 1024 beats.
- reset asserted mid-frame after 5 of 10 beats → all outputs return to reset values next cycle; no done pulse. A following start(0x000, 3) yields a clean 3-beat frame.
- start pulsed again while busy → ignored; the current frame completes unchanged.
